// File: rtl/ebus_pkg.sv
// Shared types for the Z80 expansion-bus master: command opcodes, FSM states
// and small opcode decode helpers.
package ebus_pkg;

    typedef enum logic [2:0] {
        ACQUIRE = 3'd0,
        RELEASE = 3'd1,
        MEMRD   = 3'd2,
        MEMWR   = 3'd3,
        IORD    = 3'd4,
        IOWR    = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        OWNED  = 3'd2,
        SETUP  = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5,
        REL    = 3'd6
    } state_t;

    localparam int CNT_W = 4;

    function automatic logic op_is_read(input op_t op);
        return (op == MEMRD) || (op == IORD);
    endfunction

    function automatic logic op_is_io(input op_t op);
        return (op == IORD) || (op == IOWR);
    endfunction

endpackage

// File: rtl/ebus_sync2.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to
// RST_VAL so an idle-high input reads as idle straight out of reset.
module ebus_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Synchronizer flop chain
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ebus_master_ctrl.sv
// ESP32-side master for the Z80 expansion bus: busreq/busack arbitration and
// fixed-timing memory/IO cycles. Optional REQ/REL timeout: EBUS_MASTER_TIMEOUT_EN.
module ebus_master_ctrl
    import ebus_pkg::*;
#(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2
`ifdef EBUS_MASTER_TIMEOUT_EN
    , parameter int ACK_TIMEOUT = 1023
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wrdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rddata,
    output logic        rsp_err,
    output logic        bus_owned,
    output logic        ebus_busreq_n,
    input  logic        ebus_busack_n,
    output logic [15:0] ebus_a,
    input  logic [7:0]  ebus_d_in,
    output logic [7:0]  ebus_d_out,
    output logic        ebus_d_oe,
    output logic        ebus_a_oe,
    output logic        ebus_rd_n,
    output logic        ebus_wr_n,
    output logic        ebus_mreq_n,
    output logic        ebus_iorq_n
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(T_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_t              op_q, op_d;
    logic [15:0]      a_q, a_d;
    logic [7:0]       d_out_q, d_out_d;
    logic [7:0]       rd_cap_q, rd_cap_d;
    logic [7:0]       rsp_rddata_q, rsp_rddata_d;
    logic             d_oe_q, d_oe_d;
    logic             owned_q, owned_d;
    logic             busreq_n_q, busreq_n_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;
    logic             mreq_n_q, mreq_n_d;
    logic             iorq_n_q, iorq_n_d;

    logic             ack_sync_s;
    logic             ack_s;
    logic             accept_s;
    logic             to_expired_s;
    op_t              cmd_op_s;

    ebus_sync2 #(.RST_VAL(1'b1)) u_ack_sync (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .d_i     (ebus_busack_n),
        .q_o     (ack_sync_s)
    );

    assign ack_s    = ~ack_sync_s;
    assign accept_s = cmd_valid & cmd_ready_q;
    assign cmd_op_s = op_t'(cmd_op);

`ifdef EBUS_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] to_q, to_d;

    assign to_expired_s = (to_q == TO_W'(ACK_TIMEOUT - 1));

    // Wait counter: runs only while parked in REQ or REL, cleared on any move
    always_comb begin
        to_d = '0;
        if (((state_q == REQ) || (state_q == REL)) && (state_d == state_q)) begin
            to_d = to_q + TO_W'(1);
        end else begin
            to_d = '0;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign to_expired_s = 1'b0;
`endif

    // Next-state and next-output logic for the bus sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        d_out_d      = d_out_q;
        rd_cap_d     = rd_cap_q;
        d_oe_d       = d_oe_q;
        owned_d      = owned_q;
        busreq_n_d   = busreq_n_q;
        rd_n_d       = rd_n_q;
        wr_n_d       = wr_n_q;
        mreq_n_d     = mreq_n_q;
        iorq_n_d     = iorq_n_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rddata_d = 8'h00;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    case (cmd_op_s)
                        ACQUIRE: begin
                            busreq_n_d = 1'b0;
                            state_d    = REQ;
                        end
                        RELEASE: begin
                            rsp_valid_d = 1'b1;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (ack_s) begin
                    owned_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = OWNED;
                end else if (to_expired_s) begin
                    busreq_n_d  = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            OWNED: begin
                if (accept_s) begin
                    case (cmd_op_s)
                        ACQUIRE: begin
                            rsp_valid_d = 1'b1;
                        end
                        RELEASE: begin
                            busreq_n_d = 1'b1;
                            owned_d    = 1'b0;
                            state_d    = REL;
                        end
                        MEMRD, MEMWR, IORD, IOWR: begin
                            op_d = cmd_op_s;
                            a_d  = cmd_addr;
                            if (op_is_read(cmd_op_s)) begin
                                d_oe_d = 1'b0;
                            end else begin
                                d_out_d = cmd_wrdata;
                                d_oe_d  = 1'b1;
                            end
                            cnt_d   = SETUP_LD;
                            state_d = SETUP;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = OWNED;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    // Exactly one of rd/wr and one of mreq/iorq go low together
                    rd_n_d   = ~op_is_read(op_q);
                    wr_n_d   = op_is_read(op_q);
                    mreq_n_d = op_is_io(op_q);
                    iorq_n_d = ~op_is_io(op_q);
                    cnt_d    = STROBE_LD;
                    state_d  = STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (op_is_read(op_q)) begin
                        rd_cap_d = ebus_d_in;
                    end else begin
                        rd_cap_d = rd_cap_q;
                    end
                    rd_n_d   = 1'b1;
                    wr_n_d   = 1'b1;
                    mreq_n_d = 1'b1;
                    iorq_n_d = 1'b1;
                    cnt_d    = HOLD_LD;
                    state_d  = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    d_oe_d       = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rddata_d = op_is_read(op_q) ? rd_cap_q : 8'h00;
                    state_d      = OWNED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REL: begin
                if (!ack_s) begin
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (to_expired_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = REL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE) || (state_d == OWNED);
    end

    // State and output registers; reset drops every strobe and request at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= ACQUIRE;
            a_q          <= 16'h0000;
            d_out_q      <= 8'h00;
            rd_cap_q     <= 8'h00;
            rsp_rddata_q <= 8'h00;
            d_oe_q       <= 1'b0;
            owned_q      <= 1'b0;
            busreq_n_q   <= 1'b1;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            mreq_n_q     <= 1'b1;
            iorq_n_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            d_out_q      <= d_out_d;
            rd_cap_q     <= rd_cap_d;
            rsp_rddata_q <= rsp_rddata_d;
            d_oe_q       <= d_oe_d;
            owned_q      <= owned_d;
            busreq_n_q   <= busreq_n_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            mreq_n_q     <= mreq_n_d;
            iorq_n_q     <= iorq_n_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rddata    = rsp_rddata_q;
    assign rsp_err       = rsp_err_q;
    assign bus_owned     = owned_q;
    assign ebus_a_oe     = owned_q;
    assign ebus_busreq_n = busreq_n_q;
    assign ebus_a        = a_q;
    assign ebus_d_out    = d_out_q;
    assign ebus_d_oe     = d_oe_q;
    assign ebus_rd_n     = rd_n_q;
    assign ebus_wr_n     = wr_n_q;
    assign ebus_mreq_n   = mreq_n_q;
    assign ebus_iorq_n   = iorq_n_q;

endmodule

// File: tb/tb_ebus_master_ctrl.sv
// Directed bench for ebus_master_ctrl: a hand-driven Z80 busack model, a read-data
// model, and cycle-indexed checks of arbitration and bus-cycle timing.
`timescale 1ns/1ps
module tb_ebus_master_ctrl;
    import ebus_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wrdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rddata;
    logic        rsp_err;
    logic        bus_owned;
    logic        ebus_busreq_n;
    logic        ebus_busack_n;
    logic [15:0] ebus_a;
    logic [7:0]  ebus_d_in;
    logic [7:0]  ebus_d_out;
    logic        ebus_d_oe;
    logic        ebus_a_oe;
    logic        ebus_rd_n;
    logic        ebus_wr_n;
    logic        ebus_mreq_n;
    logic        ebus_iorq_n;

    logic [7:0]  rd_model;
    int          n_checks = 0;
    int          n_errors = 0;

    // Results of one observed access window
    int          pair_first, pair_cnt, bad_cnt, doe_cnt, rsp_k, rsp_cnt;
    logic [7:0]  rsp_data_seen, dout_k1;
    logic        rsp_err_seen;
    logic [15:0] a_k1;
    int          lat;

    always #5 clk = ~clk;

    // The peripheral only drives the data bus while rd_n is low
    assign ebus_d_in = (!ebus_rd_n) ? rd_model : 8'h00;

    ebus_master_ctrl #(
        .T_SETUP  (2),
        .T_STROBE (4),
        .T_HOLD   (2)
`ifdef EBUS_MASTER_TIMEOUT_EN
        , .ACK_TIMEOUT (15)
`endif
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_wrdata    (cmd_wrdata),
        .rsp_valid     (rsp_valid),
        .rsp_rddata    (rsp_rddata),
        .rsp_err       (rsp_err),
        .bus_owned     (bus_owned),
        .ebus_busreq_n (ebus_busreq_n),
        .ebus_busack_n (ebus_busack_n),
        .ebus_a        (ebus_a),
        .ebus_d_in     (ebus_d_in),
        .ebus_d_out    (ebus_d_out),
        .ebus_d_oe     (ebus_d_oe),
        .ebus_a_oe     (ebus_a_oe),
        .ebus_rd_n     (ebus_rd_n),
        .ebus_wr_n     (ebus_wr_n),
        .ebus_mreq_n   (ebus_mreq_n),
        .ebus_iorq_n   (ebus_iorq_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n};
    endfunction

    // Present a command at a falling edge; returns at the falling edge right
    // after the accepting rising edge (cycle index 1 of the command).
    task automatic send_cmd(input op_t op, input logic [15:0] addr, input logic [7:0] wd);
        cmd_op     = op;
        cmd_addr   = addr;
        cmd_wrdata = wd;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        check_eq("cmd_ready_before_accept", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Count falling edges (from the current one) until rsp_valid, bounded
    task automatic wait_rsp(input int max_cyc, output int lat_o);
        lat_o = 0;
        while (!rsp_valid && lat_o < max_cyc) begin
            @(negedge clk);
            lat_o++;
        end
        check_eq("rsp_seen_within_bound", rsp_valid, 1'b1);
    endtask

    // Sample 12 falling edges of an access, starting at cycle index 1
    task automatic observe_access(input logic [3:0] exp_low);
        logic [3:0] low;
        pair_first = 0; pair_cnt = 0; bad_cnt = 0; doe_cnt = 0; rsp_k = 0; rsp_cnt = 0;
        rsp_data_seen = 8'h00; rsp_err_seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            low = ~strobes();
            if (low == exp_low) begin
                pair_cnt++;
                if (pair_first == 0) pair_first = k;
            end else if (low != 4'b0000) begin
                bad_cnt++;
            end
            if (ebus_d_oe) doe_cnt++;
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_k == 0) begin
                    rsp_k = k; rsp_data_seen = rsp_rddata; rsp_err_seen = rsp_err;
                end
            end
            if (k == 1) begin
                a_k1 = ebus_a; dout_k1 = ebus_d_out;
            end
            if (k < 12) @(negedge clk);
        end
    endtask

    // ACQUIRE with busack_n pulled low 3 clocks after busreq_n: two sync flops
    // plus the REQ decision put rsp_valid 3 clocks after busack_n changes.
    task automatic do_acquire();
        send_cmd(ACQUIRE, 16'h0000, 8'h00);
        check_eq("acq_busreq_low", ebus_busreq_n, 1'b0);
        check_eq("acq_no_early_rsp", rsp_valid, 1'b0);
        check_eq("acq_not_ready_in_req", cmd_ready, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("acq_not_owned_before_ack", bus_owned, 1'b0);
        ebus_busack_n = 1'b0;
        wait_rsp(20, lat);
        check_eq("acq_latency", lat, 3);
        check_eq("acq_err", rsp_err, 1'b0);
        check_eq("acq_owned", bus_owned, 1'b1);
        check_eq("acq_a_oe", ebus_a_oe, 1'b1);
        @(negedge clk);
        check_eq("acq_rsp_one_cycle", rsp_valid, 1'b0);
        check_eq("acq_ready_owned", cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        cmd_valid     = 1'b0;
        cmd_op        = 3'd0;
        cmd_addr      = 16'h0000;
        cmd_wrdata    = 8'h00;
        ebus_busack_n = 1'b1;
        rd_model      = 8'h00;
        repeat (3) @(negedge clk);

        check_eq("rst_busreq_n", ebus_busreq_n, 1'b1);
        check_eq("rst_strobes", strobes(), 4'hF);
        check_eq("rst_a", ebus_a, 16'h0000);
        check_eq("rst_d_out", ebus_d_out, 8'h00);
        check_eq("rst_d_oe", ebus_d_oe, 1'b0);
        check_eq("rst_a_oe", ebus_a_oe, 1'b0);
        check_eq("rst_owned", bus_owned, 1'b0);
        check_eq("rst_cmd_ready", cmd_ready, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_rddata", rsp_rddata, 8'h00);
        check_eq("rst_rsp_err", rsp_err, 1'b0);

        reset_n = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", cmd_ready, 1'b1);

        // Access without ownership is rejected with no bus activity
        send_cmd(MEMRD, 16'h1234, 8'h00);
        check_eq("noown_rsp", rsp_valid, 1'b1);
        check_eq("noown_err", rsp_err, 1'b1);
        check_eq("noown_rddata", rsp_rddata, 8'h00);
        check_eq("noown_strobes", strobes(), 4'hF);
        check_eq("noown_busreq_n", ebus_busreq_n, 1'b1);
        @(negedge clk);
        check_eq("noown_rsp_pulse", rsp_valid, 1'b0);

        send_cmd(RELEASE, 16'h0000, 8'h00);
        check_eq("idle_rel_rsp", rsp_valid, 1'b1);
        check_eq("idle_rel_err", rsp_err, 1'b0);

        do_acquire();

        send_cmd(ACQUIRE, 16'h0000, 8'h00);
        check_eq("owned_acq_rsp", rsp_valid, 1'b1);
        check_eq("owned_acq_err", rsp_err, 1'b0);
        check_eq("owned_acq_still_owned", bus_owned, 1'b1);

        // MEMWR: wr_n+mreq_n low for cycles 3..6, d_oe for 1..8, rsp on cycle 9
        send_cmd(MEMWR, 16'h8000, 8'h42);
        observe_access(4'b0110);
        check_eq("wr_addr", a_k1, 16'h8000);
        check_eq("wr_dout", dout_k1, 8'h42);
        check_eq("wr_strobe_start", pair_first, 3);
        check_eq("wr_strobe_len", pair_cnt, 4);
        check_eq("wr_other_strobes", bad_cnt, 0);
        check_eq("wr_doe_cycles", doe_cnt, 8);
        check_eq("wr_rsp_cycle", rsp_k, 9);
        check_eq("wr_rsp_count", rsp_cnt, 1);
        check_eq("wr_rsp_err", rsp_err_seen, 1'b0);
        check_eq("wr_rsp_rddata", rsp_data_seen, 8'h00);

        // IORD returns the value the peripheral drives while rd_n is low
        rd_model = 8'h5A;
        send_cmd(IORD, 16'h00F4, 8'h00);
        observe_access(4'b1001);
        check_eq("rd_addr", a_k1, 16'h00F4);
        check_eq("rd_strobe_start", pair_first, 3);
        check_eq("rd_strobe_len", pair_cnt, 4);
        check_eq("rd_other_strobes", bad_cnt, 0);
        check_eq("rd_doe_cycles", doe_cnt, 0);
        check_eq("rd_rsp_cycle", rsp_k, 9);
        check_eq("rd_rsp_data", rsp_data_seen, 8'h5A);
        check_eq("rd_rsp_err", rsp_err_seen, 1'b0);

        // RELEASE: rsp_valid only after busack_n has been synchronised high
        send_cmd(RELEASE, 16'h0000, 8'h00);
        check_eq("rel_busreq_n", ebus_busreq_n, 1'b1);
        check_eq("rel_owned", bus_owned, 1'b0);
        check_eq("rel_a_oe", ebus_a_oe, 1'b0);
        check_eq("rel_not_ready", cmd_ready, 1'b0);
        check_eq("rel_no_early_rsp", rsp_valid, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("rel_still_waiting", rsp_valid, 1'b0);
        ebus_busack_n = 1'b1;
        wait_rsp(20, lat);
        check_eq("rel_latency", lat, 3);
        check_eq("rel_err", rsp_err, 1'b0);
        @(negedge clk);
        check_eq("rel_idle_ready", cmd_ready, 1'b1);

        do_acquire();

        // Asynchronous reset in the middle of a write strobe
        send_cmd(MEMWR, 16'h0100, 8'hA5);
        repeat (3) @(negedge clk);
        check_eq("pre_reset_strobes", strobes(), 4'b1001);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_strobes", strobes(), 4'hF);
        check_eq("async_rst_busreq_n", ebus_busreq_n, 1'b1);
        check_eq("async_rst_d_oe", ebus_d_oe, 1'b0);
        check_eq("async_rst_owned", bus_owned, 1'b0);
        check_eq("async_rst_a_oe", ebus_a_oe, 1'b0);
        ebus_busack_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", cmd_ready, 1'b1);

`ifdef EBUS_MASTER_TIMEOUT_EN
        // Z80 never acknowledges: abort 15 clocks after the accepting edge
        send_cmd(ACQUIRE, 16'h0000, 8'h00);
        wait_rsp(40, lat);
        check_eq("to_latency", lat, 15);
        check_eq("to_err", rsp_err, 1'b1);
        check_eq("to_busreq_n", ebus_busreq_n, 1'b1);
        @(negedge clk);
        check_eq("to_idle_ready", cmd_ready, 1'b1);
        check_eq("to_not_owned", bus_owned, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ebus_master_ctrl.md
Name: ebus_master_ctrl

Overview:
Sequences ESP32-initiated accesses to the Z80 expansion bus. Takes decoded SPI commands (bus acquire, bus release, mem/IO read, mem/IO write), arbitrates ownership against the Z80 via busreq_n/busack_n, and generates Z80-style bus cycles with fixed setup/strobe/hold timing. Sits between the SPI command decoder and the ebus pad drivers in top.

Parameters:
T_SETUP, 2, clk cycles address (and write data) are driven before strobes assert; legal 1..15
T_STROBE, 4, clk cycles rd_n/wr_n plus mreq_n/iorq_n are held low; legal 1..15
T_HOLD, 2, clk cycles address/data are held after strobes deassert; legal 1..15
ACK_TIMEOUT, 1023, clk cycles to wait for busack_n before aborting (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  3  ebus_pkg::op_t: ACQUIRE, RELEASE, MEMRD, MEMWR, IORD, IOWR
cmd_addr  in  16  bus address
cmd_wrdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rddata  out  8  read data (valid with rsp_valid on MEMRD/IORD, else 0)
rsp_err  out  1  command rejected or aborted (valid with rsp_valid)
bus_owned  out  1  ESP currently owns the bus
ebus_busreq_n  out  1  bus request to Z80
ebus_busack_n  in  1  bus acknowledge from Z80 (asynchronous)
ebus_a  out  16  address
ebus_d_in  in  8  data bus input
ebus_d_out  out  8  data bus output
ebus_d_oe  out  1  data output enable
ebus_a_oe  out  1  address/strobe output enable (equals bus_owned)
ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n  out  1 each  strobes

Behaviour:
- Reset values: busreq_n=1, strobes=1, a=0, d_out=0, d_oe=0, a_oe=0, bus_owned=0, cmd_ready=0, rsp_valid=0, rsp_rddata=0, rsp_err=0. Async reset mid-cycle releases the bus immediately, with no hold phase.
- ebus_busack_n passes through a 2-flop synchronizer (ack_s, active-high internally).
- States: IDLE, REQ, OWNED, SETUP, STROBE, HOLD, REL.
- cmd_ready=1 only in IDLE and OWNED. All other states ignore commands.
- IDLE: ACQUIRE -> busreq_n=0, go REQ. RELEASE -> rsp_valid, rsp_err=0. Any access -> rsp_valid with rsp_err=1; no bus activity.
- REQ: when ack_s=1, set bus_owned=1 and a_oe=1, pulse rsp_valid, go OWNED.
- OWNED: ACQUIRE -> immediate rsp_valid, no error. RELEASE -> busreq_n=1, a_oe=0, bus_owned=0, go REL. Access -> latch addr/data/op, drive ebus_a; writes also set d_oe=1. Go SETUP.
- SETUP: T_SETUP cycles, then STROBE. In its first cycle, assert rd_n (reads) or wr_n (writes) together with mreq_n (MEM) or iorq_n (IO).
- STROBE: lasts T_STROBE cycles. On reads, ebus_d_in is captured on the last STROBE cycle. Strobes deassert entering HOLD.
- HOLD: T_HOLD cycles with a/d held. On exit: d_oe=0, rsp_valid=1 with rsp_rddata, return to OWNED.
- Access latency from accept edge to rsp_valid = T_SETUP+T_STROBE+T_HOLD+1 clocks. Default is 9.
- REL: wait until ack_s=0, then rsp_valid and IDLE.
- Only one strobe pair is ever low at a time. d_oe is never 1 during a read. No strobe is low when bus_owned=0.
- Internal counter is 4 bits, loaded with N-1 and decremented to 0.

Optional Feature:
Macro EBUS_MASTER_TIMEOUT_EN.
- With the macro: REQ counts clocks. If ack_s is still 0 after ACK_TIMEOUT clocks, set busreq_n=1, pulse rsp_valid with rsp_err=1, and return to IDLE. The same timeout applies in REL: pulse rsp_err=1, force IDLE.
- Without the macro: REQ and REL wait indefinitely, and no counter is synthesized.

Decomposition:
- Package ebus_pkg holds op_t enum (ACQUIRE=0, RELEASE=1, MEMRD=2, MEMWR=3, IORD=4, IOWR=5) and state_t.
- One sub-module, ebus_sync2: generic 2-flop synchronizer with async active-low reset and reset value 1, used for busack_n.

Test Plan:
- ACQUIRE with the model asserting busack_n 3 clocks after busreq_n -> rsp_valid 2 clocks after sync, bus_owned=1, rsp_err=0.
- MEMWR 0x8000/0x42 while owned -> a=0x8000, d_oe=1. wr_n and mreq_n are low for exactly 4 clocks, starting 2 clocks after accept. rsp_valid on clock 9. iorq_n and rd_n remain 1 throughout.
- IORD 0x00F4 with the model driving 0x5A -> rd_n and iorq_n low for 4 clocks, d_oe=0 throughout, rsp_rddata=0x5A.
- MEMRD while not owned -> rsp_valid with rsp_err=1 one clock after accept; all strobes stay 1; busreq_n stays 1.
- RELEASE while owned, then ACQUIRE -> busreq_n returns to 1, rsp_valid only after busack_n syncs high, and the new request succeeds.
- reset_n low during STROBE -> all strobes, busreq_n and d_oe return to inactive asynchronously. With EBUS_MASTER_TIMEOUT_EN and ACK_TIMEOUT=15 and busack_n never asserted -> rsp_err=1 after 15 clocks, then IDLE.
